sram_bridge: RTL and testbench

- Memory-side responder for the CPU core's instruction port (rom_*) and data port (ram_*).
- Serves both ports from one shared external asynchronous SRAM with programmable wait states.
- Holds the pipeline through stallreq_o, which feeds ctrl alongside the ID and MEM stall requests.
- Data accesses take priority; a pending fetch is served immediately after the data access.

---
 rtl/sram_bridge_pkg.sv | 47 ++++
 rtl/sram_bridge_if.sv | 26 ++
 rtl/sram_bridge.sv | 138 +++++++++++++
 tb/tb_sram_bridge.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types for the instruction/data SRAM bridge: FSM states, pad strobe bundle, defaults.
// Strobes are kept as one packed struct so the FSM can load a whole pad phase in one assignment.
package sram_bridge_pkg;

  localparam int WAIT_CYCLES_DEF = 1;
  localparam int SRAM_AW_DEF     = 20;
  localparam int REG_W           = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic       ce_n;
    logic       oe_n;
    logic       we_n;
    logic [3:0] be_n;
    logic       data_oe;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, be_n: 4'hF, data_oe: 1'b0};

  function automatic strobe_t strobe_read();
    strobe_t s;
    s.ce_n    = 1'b0;
    s.oe_n    = 1'b0;
    s.we_n    = 1'b1;
    s.be_n    = 4'h0;
    s.data_oe = 1'b0;
    return s;
  endfunction

  // The first cycle of every write has we_n low, whatever the wait-state count.
  function automatic strobe_t strobe_write(input logic [3:0] sel);
    strobe_t s;
    s.ce_n    = 1'b0;
    s.oe_n    = 1'b1;
    s.we_n    = 1'b0;
    s.be_n    = ~sel;
    s.data_oe = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/sram_bridge_if.sv
// CPU-side fetch/data port bundle of the SRAM bridge; slave = bridge, master = core.
// stallreq_o is the only backpressure: the core holds its request while it is high.
interface sram_bridge_if;
  import sram_bridge_pkg::*;

  logic             rom_ce_i;
  logic [REG_W-1:0] rom_addr_i;
  logic [REG_W-1:0] rom_data_o;
  logic             ram_ce_i;
  logic             ram_we_i;
  logic [REG_W-1:0] ram_addr_i;
  logic [REG_W-1:0] ram_data_i;
  logic [3:0]       ram_sel_i;
  logic [REG_W-1:0] ram_data_o;
  logic             stallreq_o;

  modport slave (
    input  rom_ce_i, rom_addr_i, ram_ce_i, ram_we_i, ram_addr_i, ram_data_i, ram_sel_i,
    output rom_data_o, ram_data_o, stallreq_o
  );

  modport master (
    output rom_ce_i, rom_addr_i, ram_ce_i, ram_we_i, ram_addr_i, ram_data_i, ram_sel_i,
    input  rom_data_o, ram_data_o, stallreq_o
  );
endinterface

// File: rtl/sram_bridge.sv
// Shares one async SRAM between fetch and data ports; data first, pending fetch right after.
// Single access stalls WAIT_CYCLES+2 cycles (2*WAIT_CYCLES+3 combined); results valid in DONE.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int SRAM_AW     = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram_bridge_if.slave       bus,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [REG_W-1:0]   sram_data_o,
  input  logic [REG_W-1:0]   sram_data_i,
  output logic               sram_data_oe_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic [3:0]         sram_be_n_o
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t             state;
  logic [3:0]         cnt;
  logic [3:0]         cnt_inc;
  logic               last_cycle;
  logic               req_we;
  logic               fetch_pend;
  logic [SRAM_AW-1:0] fetch_word;
  strobe_t            strobe;
  logic [SRAM_AW-1:0] addr_q;
  logic [REG_W-1:0]   wdat_q;
  logic [REG_W-1:0]   rom_q;
  logic [REG_W-1:0]   ram_q;
  logic               stall;

  assign cnt_inc    = cnt + 4'd1;
  assign last_cycle = (cnt == WAIT_LAST);

  // Byte-offset and above-window address bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.rom_addr_i, bus.ram_addr_i};

  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:       stall = bus.ram_ce_i | bus.rom_ce_i;
      DATA, INST: stall = 1'b1;
      default:    stall = 1'b0;
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_we     <= 1'b0;
      fetch_pend <= 1'b0;
      fetch_word <= '0;
      strobe     <= STROBE_IDLE;
      addr_q     <= '0;
      wdat_q     <= '0;
      rom_q      <= '0;
      ram_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (bus.ram_ce_i) begin
            state      <= DATA;
            req_we     <= bus.ram_we_i;
            fetch_pend <= bus.rom_ce_i;
            fetch_word <= bus.rom_addr_i[SRAM_AW+1:2];
            addr_q     <= bus.ram_addr_i[SRAM_AW+1:2];
            if (bus.ram_we_i) begin
              strobe <= strobe_write(bus.ram_sel_i);
              wdat_q <= bus.ram_data_i;
            end else begin
              strobe <= strobe_read();
            end
          end else if (bus.rom_ce_i) begin
            state      <= INST;
            fetch_pend <= 1'b0;
            addr_q     <= bus.rom_addr_i[SRAM_AW+1:2];
            strobe     <= strobe_read();
          end
        end
        DATA: begin
          if (last_cycle) begin
            cnt <= 4'd0;
            if (!req_we) ram_q <= sram_data_i;
            if (fetch_pend) begin
              state  <= INST;
              addr_q <= fetch_word;
              strobe <= strobe_read();
            end else begin
              state  <= DONE;
              strobe <= STROBE_IDLE;
            end
          end else begin
            cnt <= cnt_inc;
            // Release we_n one cycle early so data/address are held past the write edge.
            strobe.we_n <= !(req_we && (cnt_inc < WAIT_LAST));
          end
        end
        INST: begin
          if (last_cycle) begin
            cnt    <= 4'd0;
            rom_q  <= sram_data_i;
            state  <= DONE;
            strobe <= STROBE_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.rom_data_o = rom_q;
  assign bus.ram_data_o = ram_q;
  assign bus.stallreq_o = stall;

  assign sram_addr_o    = addr_q;
  assign sram_data_o    = wdat_q;
  assign sram_data_oe_o = strobe.data_oe;
  assign sram_ce_n_o    = strobe.ce_n;
  assign sram_oe_n_o    = strobe.oe_n;
  assign sram_we_n_o    = strobe.we_n;
  assign sram_be_n_o    = strobe.be_n;

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench: bridge with one wait state (main) and zero wait states (fetch streaming),
// each attached to a small behavioural async SRAM.
module tb_sram_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  sram_bridge_if bus1();
  sram_bridge_if bus0();

  logic [19:0] a1, a0;
  logic [31:0] wd1, wd0, sd1, sd0;
  logic        oe1, oe0, ce_n1, ce_n0, oe_n1, oe_n0, we_n1, we_n0;
  logic [3:0]  be_n1, be_n0;

  sram_bridge #(.WAIT_CYCLES(1), .SRAM_AW(20)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .sram_addr_o(a1), .sram_data_o(wd1), .sram_data_i(sd1), .sram_data_oe_o(oe1),
    .sram_ce_n_o(ce_n1), .sram_oe_n_o(oe_n1), .sram_we_n_o(we_n1), .sram_be_n_o(be_n1)
  );

  sram_bridge #(.WAIT_CYCLES(0), .SRAM_AW(20)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .sram_addr_o(a0), .sram_data_o(wd0), .sram_data_i(sd0), .sram_data_oe_o(oe0),
    .sram_ce_n_o(ce_n0), .sram_oe_n_o(oe_n0), .sram_we_n_o(we_n0), .sram_be_n_o(be_n0)
  );

  // Behavioural SRAMs: async read, byte-lane write committed on the clock edge while we_n is low.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem0 [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_dat = '0;
  logic        unused_tb;

  assign sd1 = mem1[a1[7:0]];
  assign sd0 = mem0[a0[7:0]];
  assign unused_tb = ^{a1[19:8], a0[19:8], oe_n1, oe_n0, oe0};

  always @(posedge clk) begin
    if (pre_we) mem1[pre_idx] <= pre_dat;
    else if (!ce_n1 && !we_n1)
      for (int b = 0; b < 4; b++)
        if (!be_n1[b]) mem1[a1[7:0]][8*b +: 8] <= wd1[8*b +: 8];
  end

  always @(posedge clk) begin
    if (pre_we) mem0[pre_idx] <= pre_dat;
    else if (!ce_n0 && !we_n0)
      for (int b = 0; b < 4; b++)
        if (!be_n0[b]) mem0[a0[7:0]][8*b +: 8] <= wd0[8*b +: 8];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_dat = dat;
    step();
    pre_we  = 1'b0;
  endtask

  // Observations of one access on the WAIT_CYCLES=1 bridge.
  logic [19:0] first_addr, last_addr;
  int          we_lo, we_hi;
  logic [3:0]  be_w;

  // Counts stalled cycles until the DONE cycle (stallreq low); returns positioned in DONE.
  task automatic run_access(output int n);
    bit done = 1'b0;
    n          = 0;
    first_addr = 20'hFFFFF;
    last_addr  = 20'hFFFFF;
    we_lo      = 0;
    we_hi      = 0;
    be_w       = 4'hF;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (!bus1.stallreq_o) begin
        done = 1'b1;
      end else begin
        n++;
        if (!ce_n1) begin
          if (first_addr == 20'hFFFFF) first_addr = a1;
          last_addr = a1;
          if (!we_n1) we_lo++;
          else if (oe1) we_hi++;
          if (oe1) be_w = be_n1;
        end
        step();
      end
    end
    check_val("access_end", 32'(done), 32'd1);
  endtask

  task automatic clear_bus1();
    bus1.rom_ce_i = 1'b0;
    bus1.ram_ce_i = 1'b0;
    bus1.ram_we_i = 1'b0;
  endtask

  int n;
  logic [2:0] pat;

  initial begin
    bus1.rom_ce_i = 0; bus1.rom_addr_i = 0; bus1.ram_ce_i = 0; bus1.ram_we_i = 0;
    bus1.ram_addr_i = 0; bus1.ram_data_i = 0; bus1.ram_sel_i = 0;
    bus0.rom_ce_i = 0; bus0.rom_addr_i = 0; bus0.ram_ce_i = 0; bus0.ram_we_i = 0;
    bus0.ram_addr_i = 0; bus0.ram_data_i = 0; bus0.ram_sel_i = 0;

    // Preload under reset (both memories receive the same image).
    step();
    preload(8'd0,   32'h0000_0100);
    preload(8'd1,   32'h0000_0101);
    preload(8'd2,   32'h0000_0102);
    preload(8'd3,   32'h0000_0103);
    preload(8'd4,   32'h2408_0001);
    preload(8'd5,   32'h3C01_1234);
    preload(8'd64,  32'hDEAD_BEEF);
    preload(8'd128, 32'h1122_3344);
    preload(8'd130, 32'h5555_5555);

    // Reset state: stall forced low even with a request present.
    bus1.rom_ce_i = 1'b1;
    #1;
    check_val("rst_stall", 32'(bus1.stallreq_o), 32'd0);
    bus1.rom_ce_i = 1'b0;
    check_val("rst_rom_data", bus1.rom_data_o, 32'h0);
    check_val("rst_ram_data", bus1.ram_data_o, 32'h0);
    check_val("rst_strobes", {27'd0, ce_n1, oe_n1, we_n1, oe1, 1'b0}, {27'd0, 5'b11100});
    check_val("rst_be_n", 32'(be_n1), 32'hF);
    check_val("rst_addr", 32'(a1), 32'h0);
    check_val("rst_wdata", wd1, 32'h0);
    rst = 1'b0;
    step();

    // Fetch only.
    bus1.rom_ce_i = 1'b1; bus1.rom_addr_i = 32'h0000_0010;
    run_access(n);
    check_val("fetch_stall", 32'(n), 32'd3);
    check_val("fetch_data", bus1.rom_data_o, 32'h2408_0001);
    check_val("fetch_addr", 32'(first_addr), 32'd4);
    check_val("done_ce_n", 32'(ce_n1), 32'd1);
    clear_bus1();
    step();

    // Simultaneous data read and fetch: data first.
    bus1.ram_ce_i = 1'b1; bus1.ram_we_i = 1'b0; bus1.ram_addr_i = 32'h0000_0100;
    bus1.rom_ce_i = 1'b1; bus1.rom_addr_i = 32'h0000_0014;
    run_access(n);
    check_val("both_stall", 32'(n), 32'd5);
    check_val("both_ram_data", bus1.ram_data_o, 32'hDEAD_BEEF);
    check_val("both_rom_data", bus1.rom_data_o, 32'h3C01_1234);
    check_val("both_first_addr", 32'(first_addr), 32'd64);
    check_val("both_last_addr", 32'(last_addr), 32'd5);
    clear_bus1();
    step();

    // Byte write to lane 1 of word 128.
    bus1.ram_ce_i = 1'b1; bus1.ram_we_i = 1'b1; bus1.ram_addr_i = 32'h0000_0200;
    bus1.ram_data_i = 32'h0000_AB00; bus1.ram_sel_i = 4'b0010;
    run_access(n);
    check_val("wr_stall", 32'(n), 32'd3);
    check_val("wr_be_n", 32'(be_w), 32'(4'b1101));
    check_val("wr_we_low", 32'(we_lo), 32'd1);
    check_val("wr_we_hold", 32'(we_hi), 32'd1);
    check_val("wr_ram_data", bus1.ram_data_o, 32'hDEAD_BEEF);
    check_val("wr_mem", mem1[128], 32'h1122_AB44);
    clear_bus1();
    step();

    // Reset in the second write cycle.
    bus1.ram_ce_i = 1'b1; bus1.ram_we_i = 1'b1; bus1.ram_addr_i = 32'h0000_0208;
    bus1.ram_data_i = 32'hA5A5_A5A5; bus1.ram_sel_i = 4'hF;
    #1;
    check_val("rw_idle_stall", 32'(bus1.stallreq_o), 32'd1);
    step();
    check_val("rw_we_c0", 32'(we_n1), 32'd0);
    step();
    check_val("rw_we_c1", 32'(we_n1), 32'd1);
    rst = 1'b1;
    #1;
    check_val("rw_rst_stall", 32'(bus1.stallreq_o), 32'd0);
    step();
    check_val("rw_strobes", {28'd0, ce_n1, we_n1, oe1, 1'b0}, {28'd0, 4'b1100});
    check_val("rw_be_n", 32'(be_n1), 32'hF);
    rst = 1'b0;
    clear_bus1();
    step();
    check_val("rw_idle", 32'(bus1.stallreq_o), 32'd0);
    check_val("rw_mem", mem1[130], 32'hA5A5_A5A5);

    // Upper address bits dropped: 0xFFC0_0008 -> word 2.
    bus1.rom_ce_i = 1'b1; bus1.rom_addr_i = 32'hFFC0_0008;
    run_access(n);
    check_val("wrap_stall", 32'(n), 32'd3);
    check_val("wrap_addr", 32'(first_addr), 32'h0_0002);
    check_val("wrap_data", bus1.rom_data_o, 32'h0000_0102);
    clear_bus1();
    step();

    // Zero wait states, fetch held every IDLE: stall 1,1,0 repeating, words in order.
    for (int k = 0; k < 4; k++) begin
      bus0.rom_ce_i   = 1'b1;
      bus0.rom_addr_i = 32'(4 * k);
      pat = 3'b000;
      for (int j = 0; j < 3; j++) begin
        #1;
        pat = {pat[1:0], bus0.stallreq_o};
        if (j < 2) step();
      end
      check_val($sformatf("w0_pat%0d", k), 32'(pat), 32'(3'b110));
      check_val($sformatf("w0_data%0d", k), bus0.rom_data_o, 32'h0000_0100 + 32'(k));
      step();
    end
    bus0.rom_ce_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
